// File: rtl/uart_rx.sv
// 8N1 serial receiver sampled on a shared OVERSAMPLE x baud strobe; pushes good bytes to a FIFO.
// Optional build macro UART_RX_MAJORITY_EN enables 2-of-3 majority voting of each sample.
module uart_rx #(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_bit,
  input  logic                 sample_tick,
  input  logic                 fifo_full,
  output logic                 push,
  output logic [DATA_BITS-1:0] data,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] STOP      = 3'd3;
  localparam logic [2:0] WAIT_IDLE = 3'd4;

  localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
  localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

`ifdef UART_RX_MAJORITY_EN
  // Decision lands one tick past the nominal point so the vote window is centred on it.
  localparam int unsigned START_PT = OVERSAMPLE / 2;
`else
  localparam int unsigned START_PT = OVERSAMPLE / 2 - 1;
`endif

  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(START_PT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;
  logic                   s;

  logic [2:0]           state_q, state_d;
  logic [CNT_W-1:0]     tick_q, tick_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d, shreg_shift;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 push_q, push_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;

  always_ff @(posedge clk) begin
    if (reset) sync_q <= '1;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], rx_bit};
  end

  assign rxs = sync_q[SYNC_STAGES-1];

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] vote_q;

  always_ff @(posedge clk) begin
    if (reset)            vote_q <= 2'b11;
    else if (sample_tick) vote_q <= {vote_q[0], rxs};
  end

  assign s = (vote_q[1] & vote_q[0]) | (vote_q[1] & rxs) | (vote_q[0] & rxs);
`else
  assign s = rxs;
`endif

  // LSB arrives first, so bits enter at the MSB and walk down.
  if (DATA_BITS == 1) begin : g_shift_one
    assign shreg_shift = s;
  end else begin : g_shift_many
    assign shreg_shift = {s, shreg_q[DATA_BITS-1:1]};
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    push_d  = 1'b0;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
    if (sample_tick) begin
      tick_d = tick_q + 1'b1;
      case (state_q)
        IDLE: begin
          tick_d = '0;
          if (!rxs) state_d = START;
        end
        START: begin
          if (tick_q == CNT_MID) begin
            tick_d  = '0;
            idx_d   = '0;
            state_d = s ? IDLE : DATA;
          end
        end
        DATA: begin
          if (tick_q == CNT_LAST) begin
            tick_d  = '0;
            shreg_d = shreg_shift;
            idx_d   = idx_q + 1'b1;
            if (idx_q == IDX_LAST) state_d = STOP;
          end
        end
        STOP: begin
          if (tick_q == CNT_LAST) begin
            tick_d = '0;
            if (!s) begin
              ferr_d  = 1'b1;
              state_d = WAIT_IDLE;
            end else if (fifo_full) begin
              ovr_d   = 1'b1;
              state_d = IDLE;
            end else begin
              push_d  = 1'b1;
              data_d  = shreg_q;
              state_d = IDLE;
            end
          end
        end
        WAIT_IDLE: begin
          // Break condition: hold here so a low line cannot spawn phantom frames.
          tick_d = '0;
          if (rxs) state_d = IDLE;
        end
        default: begin
          tick_d  = '0;
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      tick_q  <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      push_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      push_q  <= push_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign push      = push_q;
  assign data      = data_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus random frames against a frame-level model.
module tb_uart_rx;

  localparam int OS     = 16;
  localparam int BITCLK = OS * 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_bit;
  logic       sample_tick;
  logic       fifo_full;
  logic       push;
  logic [7:0] data;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  logic [1:0] tdiv = 2'd0;

  int n_checks = 0;
  int n_pass   = 0;
  int n_push   = 0;
  int n_ferr   = 0;
  int n_ovr    = 0;
  int viol     = 0;
  int exp_push = 0;
  int exp_ferr = 0;
  int exp_ovr  = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic prev_any  = 1'b0;
  logic prev_tick = 1'b0;

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(OS), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_bit     (rx_bit),
    .sample_tick(sample_tick),
    .fifo_full  (fifo_full),
    .push       (push),
    .data       (data),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) tdiv <= tdiv + 2'd1;
  assign sample_tick = (tdiv == 2'd3);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Output monitor: collects pulses and checks exclusivity and one-clk-after-tick latency.
  always @(negedge clk) begin
    logic any;
    any = push | frame_err | overrun;
    if (!reset) begin
      if (push) begin
        got_q.push_back(data);
        n_push++;
        chk("push_after_tick", {31'd0, prev_tick}, 32'd1);
      end
      if (frame_err) n_ferr++;
      if (overrun) n_ovr++;
      if ((int'(push) + int'(frame_err) + int'(overrun)) > 1 || (any && prev_any)) viol++;
    end
    prev_any  = any;
    prev_tick = sample_tick;
  end

  task automatic line(input logic v, input int clks);
    @(negedge clk);
    rx_bit = v;
    repeat (clks - 1) @(negedge clk);
  endtask

  // glitch_bit < 0 disables the glitch; otherwise that data bit is inverted for one tick at mid-bit.
  task automatic send(input logic [7:0] b, input logic stop, input int glitch_bit);
    line(1'b0, BITCLK);
    for (int i = 0; i < 8; i++) begin
      if (i == glitch_bit) begin
        line(b[i], BITCLK / 2 - 2);
        line(~b[i], 4);
        line(b[i], BITCLK / 2 - 2);
      end else begin
        line(b[i], BITCLK);
      end
    end
    line(stop, BITCLK);
  endtask

  // Frame-level model: a good stop either pushes or overruns, a bad stop is a framing error.
  task automatic model(input logic [7:0] b, input logic stop, input logic full);
    if (!stop) exp_ferr++;
    else if (full) exp_ovr++;
    else begin
      exp_push++;
      exp_q.push_back(b);
    end
  endtask

  task automatic check_counts(input string tag);
    chk({tag, "_push"}, n_push, exp_push);
    chk({tag, "_ferr"}, n_ferr, exp_ferr);
    chk({tag, "_ovr"}, n_ovr, exp_ovr);
  endtask

  initial begin
    logic [7:0] b;
    logic       st;
    logic       ff;
    reset     = 1'b1;
    rx_bit    = 1'b1;
    fifo_full = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_push", {31'd0, push}, 32'd0);
    chk("rst_data", {24'd0, data}, 32'd0);
    chk("rst_ferr", {31'd0, frame_err}, 32'd0);
    chk("rst_ovr", {31'd0, overrun}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    line(1'b1, BITCLK);

    send(8'hA5, 1'b1, -1);
    model(8'hA5, 1'b1, 1'b0);
    chk("a5_data", {24'd0, data}, 32'h0A5);
    check_counts("a5");
    line(1'b1, BITCLK);

    send(8'h00, 1'b1, -1);
    model(8'h00, 1'b1, 1'b0);
    send(8'hFF, 1'b1, -1);
    model(8'hFF, 1'b1, 1'b0);
    line(1'b1, BITCLK);
    check_counts("b2b");
    chk("b2b_data", {24'd0, data}, 32'h0FF);

    line(1'b0, 12);
    chk("false_start_busy_hi", {31'd0, busy}, 32'd1);
    line(1'b1, BITCLK);
    chk("false_start_busy_lo", {31'd0, busy}, 32'd0);
    check_counts("false_start");

    send(8'h3C, 1'b0, -1);
    model(8'h3C, 1'b0, 1'b0);
    line(1'b0, 40 * 4);
    check_counts("break");
    chk("break_busy", {31'd0, busy}, 32'd1);
    line(1'b1, BITCLK);
    chk("break_idle_busy", {31'd0, busy}, 32'd0);
    send(8'h11, 1'b1, -1);
    model(8'h11, 1'b1, 1'b0);
    line(1'b1, BITCLK);
    chk("after_break_data", {24'd0, data}, 32'h011);
    check_counts("after_break");

    fifo_full = 1'b1;
    send(8'h5A, 1'b1, -1);
    model(8'h5A, 1'b1, 1'b1);
    line(1'b1, BITCLK);
    fifo_full = 1'b0;
    chk("ovr_data_held", {24'd0, data}, 32'h011);
    check_counts("ovr");

    // Reset during data bit 0 of 0x77, then a clean 0x81.
    line(1'b0, BITCLK);
    line(1'b1, BITCLK / 2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midreset_busy", {31'd0, busy}, 32'd0);
    line(1'b1, 2 * BITCLK);
    send(8'h81, 1'b1, -1);
    model(8'h81, 1'b1, 1'b0);
    line(1'b1, BITCLK);
    chk("midreset_data", {24'd0, data}, 32'h081);
    check_counts("midreset");

`ifdef UART_RX_MAJORITY_EN
    send(8'h81, 1'b1, 1);
    model(8'h81, 1'b1, 1'b0);
    line(1'b1, BITCLK);
    chk("glitch_data", {24'd0, data}, 32'h081);
    check_counts("glitch");
`endif

    for (int k = 0; k < 12; k++) begin
      b  = 8'($urandom);
      st = ($urandom_range(0, 4) != 0);
      ff = ($urandom_range(0, 3) == 0);
      fifo_full = ff;
      send(b, st, -1);
      model(b, st, ff);
      line(1'b1, BITCLK);
      fifo_full = 1'b0;
    end
    check_counts("random");

    chk("queue_len", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk($sformatf("byte%0d", i), {24'd0, got_q[i]}, {24'd0, exp_q[i]});
    end
    chk("pulse_rules", viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
